// File: rtl/gusn_fixed_pkg.sv
// Shared fixed-point types and limits for the GUSN divider and multiplier.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package gusn_fixed_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } div_state_t;

    // Limits are returned as magnitudes; callers cast to the width they need.
    function automatic logic [63:0] max_pos(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] max_neg(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/fixed_sat.sv
// Applies a sign to an unsigned magnitude and saturates it to signed NUM_W.
// Latency: combinational.
// Backpressure: none.
module fixed_sat
    import gusn_fixed_pkg::*;
#(
    parameter int MAG_W = 29,
    parameter int NUM_W = 16
) (
    input  logic [MAG_W-1:0] mag,
    input  logic             neg,
    output logic [NUM_W-1:0] res
);

    localparam logic [MAG_W-1:0] POS_LIM = MAG_W'(max_pos(NUM_W));
    localparam logic [MAG_W-1:0] NEG_LIM = MAG_W'(max_neg(NUM_W));

    logic [NUM_W-1:0] lo;
    assign lo = mag[NUM_W-1:0];

    // A zero magnitude negates to zero, so -0 never appears.
    always_comb begin
        res = lo;
        if (neg) begin
            res = (mag > NEG_LIM) ? NUM_W'(max_neg(NUM_W)) : (~lo + NUM_W'(1));
        end else if (mag > POS_LIM) begin
            res = NUM_W'(max_pos(NUM_W));
        end
    end

endmodule

// File: rtl/fixed_div.sv
// Iterative signed Q(INT_W).(FRAC_W) divider, restoring, one quotient bit per clock; FIXED_DIV_ROUND_EN enables round-half-away.
// Latency: div_done pulses N+1 cycles after start acceptance (N = NUM_W+FRAC_W+SHIFT); back-to-back period N+2.
// Backpressure: none; div_start is only sampled in IDLE, starts while busy are dropped.
module fixed_div
    import gusn_fixed_pkg::*;
#(
    parameter  int INT_W  = 8,
    parameter  int FRAC_W = 8,
    parameter  int SHIFT  = 4,
    localparam int NUM_W  = INT_W + FRAC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             div_start,
    input  logic [NUM_W-1:0] div_v1,
    input  logic [NUM_W-1:0] div_v2,
    input  logic             div_shift,
    output logic             div_busy,
    output logic             div_done,
    output logic [NUM_W-1:0] div_res,
    output logic             div_zero
);

    localparam int N     = NUM_W + FRAC_W + SHIFT;
    localparam int CNT_W = $clog2(N + 1);

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [N-1:0]     quo;
    logic [NUM_W:0]   rem;
    logic [NUM_W-1:0] dvs;
    logic             neg;
    logic             dz;

    logic [NUM_W-1:0] abs1, abs2;
    logic [N-1:0]     num_full, num_ld;
    logic [NUM_W+1:0] trial;
    logic             ge;
    logic [NUM_W+1:0] diff;
    logic             rnd;
    logic [N:0]       mag;
    logic [NUM_W-1:0] sat_res;

    assign abs1 = div_v1[NUM_W-1] ? (~div_v1 + NUM_W'(1)) : div_v1;
    assign abs2 = div_v2[NUM_W-1] ? (~div_v2 + NUM_W'(1)) : div_v2;

    // The unscaled case reuses the scaled datapath by pre-shifting the numerator down.
    assign num_full = {abs1, {(FRAC_W + SHIFT){1'b0}}};
    assign num_ld   = div_shift ? num_full : (num_full >> SHIFT);

    assign trial = {rem, quo[N-1]};
    assign ge    = trial >= {2'b00, dvs};
    assign diff  = trial - {2'b00, dvs};

`ifdef FIXED_DIV_ROUND_EN
    // A zero divisor already yields an all-ones quotient; rounding must not wrap it.
    assign rnd = !dz && ({rem, 1'b0} >= {2'b00, dvs});
`else
    assign rnd = 1'b0;
`endif

    assign mag = {1'b0, quo} + {{N{1'b0}}, rnd};

    fixed_sat #(
        .MAG_W(N + 1),
        .NUM_W(NUM_W)
    ) u_sat (
        .mag(mag),
        .neg(neg),
        .res(sat_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            quo      <= '0;
            rem      <= '0;
            dvs      <= '0;
            neg      <= 1'b0;
            dz       <= 1'b0;
            div_busy <= 1'b0;
            div_done <= 1'b0;
            div_res  <= '0;
            div_zero <= 1'b0;
        end else begin
            div_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (div_start) begin
                        quo      <= num_ld;
                        rem      <= '0;
                        dvs      <= abs2;
                        neg      <= div_v1[NUM_W-1] ^ div_v2[NUM_W-1];
                        dz       <= (div_v2 == '0);
                        cnt      <= '0;
                        div_busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    quo <= {quo[N-2:0], ge};
                    rem <= ge ? diff[NUM_W:0] : trial[NUM_W:0];
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(N - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    div_res  <= sat_res;
                    div_zero <= dz;
                    div_done <= 1'b1;
                    div_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
